// File: rtl/aes_round_ctrl.sv
// AES round sequencer: walks one block through the round stages in encrypt or
// decrypt order, driving registered stage enables, round number and key index.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       abort,
  output logic       ready,
  output logic       done,
  output logic       inv,
  output logic       load,
  output logic       sub_en,
  output logic       shift_en,
  output logic       mix_en,
  output logic       ark_en,
  output logic [3:0] round,
  output logic [3:0] key_idx
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ARK0, SUB, SHIFT, MIX, ARK, DONE
  } state_t;

  localparam logic [3:0] LP_NR = 4'(NR);

  state_t     r_state, w_nextState;
  logic [3:0] r_round, w_nextRound;
  logic [3:0] r_keyIdx, w_nextKeyIdx;
  logic       r_inv, w_nextInv;
  logic       r_ready, r_done, r_load, r_sub, r_shift, r_mix, r_ark;
  logic       w_lastRound;

  assign w_lastRound = (r_round == LP_NR);

  // Decrypt runs SHIFT-SUB-ARK-MIX so the round counter advances out of MIX,
  // while encrypt advances out of ARK; the last round never visits MIX.
  always_comb begin
    w_nextState  = r_state;
    w_nextRound  = r_round;
    w_nextInv    = r_inv;
    w_nextKeyIdx = r_keyIdx;
    case (r_state)
      IDLE: begin
        w_nextRound = 4'd0;
        if (start && !abort) begin
          w_nextState = LOAD;
          w_nextInv   = mode;
        end
      end
      LOAD: begin
        w_nextState = ARK0;
        w_nextRound = 4'd0;
      end
      ARK0: begin
        w_nextRound = 4'd1;
        w_nextState = r_inv ? SHIFT : SUB;
      end
      SUB:   w_nextState = r_inv ? ARK : SHIFT;
      SHIFT: begin
        if (r_inv)            w_nextState = SUB;
        else if (w_lastRound) w_nextState = ARK;
        else                  w_nextState = MIX;
      end
      MIX: begin
        if (r_inv) begin
          w_nextState = SHIFT;
          w_nextRound = r_round + 4'd1;
        end else begin
          w_nextState = ARK;
        end
      end
      ARK: begin
        if (w_lastRound) begin
          w_nextState = DONE;
        end else if (r_inv) begin
          w_nextState = MIX;
        end else begin
          w_nextState = SUB;
          w_nextRound = r_round + 4'd1;
        end
      end
      DONE: begin
        w_nextState = IDLE;
        w_nextRound = 4'd0;
      end
      default: w_nextState = IDLE;
    endcase

    if (abort && r_state != IDLE) begin
      w_nextState = IDLE;
      w_nextRound = 4'd0;
    end

    // The key index only moves when an AddRoundKey cycle is coming up.
    if (w_nextState == ARK0 || w_nextState == ARK)
      w_nextKeyIdx = w_nextInv ? (LP_NR - w_nextRound) : w_nextRound;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_round  <= 4'd0;
      r_keyIdx <= 4'd0;
      r_inv    <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_load   <= 1'b0;
      r_sub    <= 1'b0;
      r_shift  <= 1'b0;
      r_mix    <= 1'b0;
      r_ark    <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_round  <= w_nextRound;
      r_keyIdx <= w_nextKeyIdx;
      r_inv    <= w_nextInv;
      r_ready  <= (w_nextState == IDLE);
      r_done   <= (w_nextState == DONE);
      r_load   <= (w_nextState == LOAD);
      r_sub    <= (w_nextState == SUB);
      r_shift  <= (w_nextState == SHIFT);
      r_mix    <= (w_nextState == MIX);
      r_ark    <= (w_nextState == ARK0) || (w_nextState == ARK);
    end
  end

  assign ready    = r_ready;
  assign done     = r_done;
  assign inv      = r_inv;
  assign load     = r_load;
  assign sub_en   = r_sub;
  assign shift_en = r_shift;
  assign mix_en   = r_mix;
  assign ark_en   = r_ark;
  assign round    = r_round;
  assign key_idx  = r_keyIdx;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: per-cycle scoreboard of expected controller outputs plus
// an AES-128 datapath model steered by the controller's enables and key index.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start10 = 1'b0, mode10 = 1'b0, abort10 = 1'b0;
  logic start14 = 1'b0, mode14 = 1'b0, abort14 = 1'b0;
  logic ready10, done10, inv10, load10, sub10, shift10, mix10, ark10;
  logic ready14, done14, inv14, load14, sub14, shift14, mix14, ark14;
  logic [3:0] round10, key10, round14, key14;
  logic [6:0] f10, f14;

  assign f10 = {ready10, done10, load10, sub10, shift10, mix10, ark10};
  assign f14 = {ready14, done14, load14, sub14, shift14, mix14, ark14};

  aes_round_ctrl #(.NR(10)) dut10 (
    .clk(clk), .rst(rst), .start(start10), .mode(mode10), .abort(abort10),
    .ready(ready10), .done(done10), .inv(inv10), .load(load10), .sub_en(sub10),
    .shift_en(shift10), .mix_en(mix10), .ark_en(ark10), .round(round10), .key_idx(key10)
  );

  aes_round_ctrl #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .start(start14), .mode(mode14), .abort(abort14),
    .ready(ready14), .done(done14), .inv(inv14), .load(load14), .sub_en(sub14),
    .shift_en(shift14), .mix_en(mix14), .ark_en(ark14), .round(round14), .key_idx(key14)
  );

  // Flag order: ready, done, load, sub, shift, mix, ark.
  localparam logic [6:0] F_READY = 7'b1000000;
  localparam logic [6:0] F_DONE  = 7'b0100000;
  localparam logic [6:0] F_LOAD  = 7'b0010000;
  localparam logic [6:0] F_SUB   = 7'b0001000;
  localparam logic [6:0] F_SHIFT = 7'b0000100;
  localparam logic [6:0] F_MIX   = 7'b0000010;
  localparam logic [6:0] F_ARK   = 7'b0000001;

  typedef struct packed {
    logic [6:0] flags;
    logic       inv;
    logic       chkRound;
    logic [3:0] round;
    logic [3:0] key;
  } rec_t;

  rec_t q10[$];
  rec_t q14[$];
  logic [3:0] pushKey10 = 4'd0, pushKey14 = 4'd0;
  int checks = 0;
  int fails  = 0;

  logic [7:0]   sbox [256];
  logic [7:0]   isbox[256];
  logic [31:0]  w    [44];
  logic [7:0]   st   [16];
  logic [127:0] dataIn = '0;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a, y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [127:0] blockOut();
    logic [127:0] res;
    for (int k = 0; k < 16; k++) res[127 - 8*k -: 8] = st[k];
    return res;
  endfunction

  task automatic buildTables();
    logic [7:0] b, s, rcon;
    logic [31:0] t;
    for (int i = 0; i < 256; i++) begin
      b = 8'h00;
      for (int j = 1; j < 256; j++)
        if (gmul(8'(i), 8'(j)) == 8'h01) b = 8'(j);
      s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
      sbox[i]  = s;
      isbox[s] = 8'(i);
    end
    for (int i = 0; i < 4; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
  endtask

  // Reference AES-128 state, advanced by whatever stage the controller enables.
  always @(negedge clk) begin
    logic [7:0] nxt [16];
    logic [7:0] a0, a1, a2, a3;
    for (int k = 0; k < 16; k++) nxt[k] = st[k];
    if (load10 === 1'b1) begin
      for (int k = 0; k < 16; k++) nxt[k] = dataIn[127 - 8*k -: 8];
    end else if (sub10 === 1'b1) begin
      for (int k = 0; k < 16; k++) nxt[k] = inv10 ? isbox[st[k]] : sbox[st[k]];
    end else if (shift10 === 1'b1) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (inv10) nxt[r + 4*((c + r) % 4)] = st[r + 4*c];
          else       nxt[r + 4*c] = st[r + 4*((c + r) % 4)];
    end else if (mix10 === 1'b1) begin
      for (int c = 0; c < 4; c++) begin
        a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
        if (!inv10) begin
          nxt[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          nxt[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          nxt[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          nxt[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          nxt[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          nxt[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          nxt[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          nxt[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
      end
    end else if (ark10 === 1'b1) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          nxt[4*c + r] = st[4*c + r] ^ w[4*int'(key10) + c][31 - 8*r -: 8];
    end
    for (int k = 0; k < 16; k++) st[k] <= nxt[k];
  end

  task automatic pushRec(input int which, input rec_t r);
    if (which == 14) q14.push_back(r);
    else             q10.push_back(r);
  endtask

  // Expected per-cycle trace of one accepted operation, LOAD through the IDLE after DONE.
  task automatic pushOp(input int which, input int nr, input logic md);
    logic [3:0] k, kr;
    k = (which == 14) ? pushKey14 : pushKey10;
    pushRec(which, {F_LOAD, md, 1'b0, 4'd0, k});
    k = md ? 4'(nr) : 4'd0;
    pushRec(which, {F_ARK, md, 1'b1, 4'd0, k});
    for (int r = 1; r <= nr; r++) begin
      kr = md ? 4'(nr - r) : 4'(r);
      if (!md) begin
        pushRec(which, {F_SUB, md, 1'b1, 4'(r), k});
        pushRec(which, {F_SHIFT, md, 1'b1, 4'(r), k});
        if (r < nr) pushRec(which, {F_MIX, md, 1'b1, 4'(r), k});
        k = kr;
        pushRec(which, {F_ARK, md, 1'b1, 4'(r), k});
      end else begin
        pushRec(which, {F_SHIFT, md, 1'b1, 4'(r), k});
        pushRec(which, {F_SUB, md, 1'b1, 4'(r), k});
        k = kr;
        pushRec(which, {F_ARK, md, 1'b1, 4'(r), k});
        if (r < nr) pushRec(which, {F_MIX, md, 1'b1, 4'(r), k});
      end
    end
    pushRec(which, {F_DONE, md, 1'b0, 4'd0, k});
    pushRec(which, {F_READY, md, 1'b0, 4'd0, k});
    if (which == 14) pushKey14 = k;
    else             pushKey10 = k;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (f10 !== F_READY) begin
      fails++; $display("[TB] FAIL reset_flags10 got %b want %b", f10, F_READY);
    end
    checks++;
    if ({inv10, round10, key10} !== 9'd0) begin
      fails++; $display("[TB] FAIL reset_regs10 got inv=%b round=%0d key=%0d want 0/0/0", inv10, round10, key10);
    end
    checks++;
    if (f14 !== F_READY) begin
      fails++; $display("[TB] FAIL reset_flags14 got %b want %b", f14, F_READY);
    end
    checks++;
    if ({inv14, round14, key14} !== 9'd0) begin
      fails++; $display("[TB] FAIL reset_regs14 got inv=%b round=%0d key=%0d want 0/0/0", inv14, round14, key14);
    end
    rst = 1'b0;
    pushKey10 = 4'd0;
    pushKey14 = 4'd0;
  endtask

  task automatic test_encrypt();
    rec_t e;
    int idx = 0, doneIdx = -1, readyIdx = -1;
    @(negedge clk);
    dataIn = 128'h00112233445566778899aabbccddeeff;
    mode10 = 1'b0; start10 = 1'b1;
    pushOp(10, 10, 1'b0);
    while (q10.size() > 0) begin
      @(negedge clk);
      e = q10.pop_front();
      checks++;
      if ({f10, inv10, key10} !== {e.flags, e.inv, e.key} || (e.chkRound && round10 !== e.round)) begin
        fails++;
        $display("[TB] FAIL enc_seq idx=%0d got %b/%b/r%0d/k%0d want %b/%b/r%0d/k%0d",
                 idx, f10, inv10, round10, key10, e.flags, e.inv, e.round, e.key);
      end
      if (done10 === 1'b1 && doneIdx < 0) doneIdx = idx;
      if (ready10 === 1'b1 && doneIdx >= 0 && readyIdx < 0) readyIdx = idx;
      start10 = 1'b0;
      idx++;
    end
    checks++;
    if (doneIdx !== 41) begin
      fails++; $display("[TB] FAIL enc_done_latency got %0d want 41", doneIdx);
    end
    checks++;
    if (readyIdx !== 42) begin
      fails++; $display("[TB] FAIL enc_ready_latency got %0d want 42", readyIdx);
    end
    checks++;
    if (blockOut() !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      fails++; $display("[TB] FAIL enc_cipher got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", blockOut());
    end
  endtask

  // Mode toggles and a start pulse while busy must not disturb the decrypt run.
  task automatic test_decrypt();
    rec_t e;
    int idx = 0;
    @(negedge clk);
    dataIn = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    mode10 = 1'b1; start10 = 1'b1;
    pushOp(10, 10, 1'b1);
    while (q10.size() > 0) begin
      @(negedge clk);
      e = q10.pop_front();
      checks++;
      if ({f10, inv10, key10} !== {e.flags, e.inv, e.key} || (e.chkRound && round10 !== e.round)) begin
        fails++;
        $display("[TB] FAIL dec_seq idx=%0d got %b/%b/r%0d/k%0d want %b/%b/r%0d/k%0d",
                 idx, f10, inv10, round10, key10, e.flags, e.inv, e.round, e.key);
      end
      start10 = (idx == 10);
      mode10  = (idx < 38) ? ~mode10 : 1'b0;
      idx++;
    end
    checks++;
    if (blockOut() !== 128'h00112233445566778899aabbccddeeff) begin
      fails++; $display("[TB] FAIL dec_plain got %h want 00112233445566778899aabbccddeeff", blockOut());
    end
  endtask

  task automatic test_nr14();
    rec_t e;
    int idx = 0, doneIdx = -1, mixCount = 0, maxRound = 0;
    @(negedge clk);
    mode14 = 1'b0; start14 = 1'b1;
    pushOp(14, 14, 1'b0);
    while (q14.size() > 0) begin
      @(negedge clk);
      e = q14.pop_front();
      checks++;
      if ({f14, inv14, key14} !== {e.flags, e.inv, e.key} || (e.chkRound && round14 !== e.round)) begin
        fails++;
        $display("[TB] FAIL nr14_seq idx=%0d got %b/%b/r%0d/k%0d want %b/%b/r%0d/k%0d",
                 idx, f14, inv14, round14, key14, e.flags, e.inv, e.round, e.key);
      end
      if (done14 === 1'b1 && doneIdx < 0) doneIdx = idx;
      if (mix14 === 1'b1) mixCount++;
      if (int'(round14) > maxRound) maxRound = int'(round14);
      start14 = 1'b0;
      idx++;
    end
    checks++;
    if (doneIdx !== 57 || mixCount !== 13 || maxRound !== 14) begin
      fails++;
      $display("[TB] FAIL nr14_totals got done=%0d mix=%0d rounds=%0d want 57/13/14", doneIdx, mixCount, maxRound);
    end
  endtask

  task automatic test_abort();
    rec_t e;
    int idx = 0;
    bit restarted = 1'b0;
    @(negedge clk);
    dataIn = 128'h00112233445566778899aabbccddeeff;
    mode10 = 1'b0; start10 = 1'b1;
    pushOp(10, 10, 1'b0);
    while (q10.size() > 0) begin
      @(negedge clk);
      e = q10.pop_front();
      checks++;
      if ({f10, inv10, key10} !== {e.flags, e.inv, e.key} || (e.chkRound && round10 !== e.round)) begin
        fails++;
        $display("[TB] FAIL abort_seq idx=%0d got %b/%b/r%0d/k%0d want %b/%b/r%0d/k%0d",
                 idx, f10, inv10, round10, key10, e.flags, e.inv, e.round, e.key);
      end
      if (idx == 0) start10 = 1'b0;
      if (!restarted && idx == 20) begin
        abort10 = 1'b1;
        q10.delete();
        pushKey10 = e.key;
        pushRec(10, {F_READY, 1'b0, 1'b1, 4'd0, e.key});
      end else if (!restarted && idx == 21) begin
        abort10 = 1'b0;
        start10 = 1'b1;
        pushOp(10, 10, 1'b0);
        restarted = 1'b1;
        idx = -1;
      end
      idx++;
    end
    checks++;
    if (blockOut() !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      fails++; $display("[TB] FAIL abort_restart_cipher got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", blockOut());
    end
  endtask

  task automatic test_abort_idle();
    @(negedge clk);
    start10 = 1'b1; abort10 = 1'b1;
    @(negedge clk);
    checks++;
    if ({f10, key10} !== {F_READY, pushKey10}) begin
      fails++; $display("[TB] FAIL abort_start_idle got %b/k%0d want %b/k%0d", f10, key10, F_READY, pushKey10);
    end
    start10 = 1'b0; abort10 = 1'b0;
    @(negedge clk);
    checks++;
    if (f10 !== F_READY) begin
      fails++; $display("[TB] FAIL abort_start_not_queued got %b want %b", f10, F_READY);
    end
  endtask

  task automatic test_abort_done();
    rec_t e;
    int idx = 0;
    @(negedge clk);
    mode10 = 1'b0; start10 = 1'b1;
    pushOp(10, 10, 1'b0);
    repeat (3) pushRec(10, {F_READY, 1'b0, 1'b0, 4'd0, pushKey10});
    while (q10.size() > 0) begin
      @(negedge clk);
      e = q10.pop_front();
      checks++;
      if ({f10, inv10, key10} !== {e.flags, e.inv, e.key} || (e.chkRound && round10 !== e.round)) begin
        fails++;
        $display("[TB] FAIL abort_done_seq idx=%0d got %b/%b/r%0d/k%0d want %b/%b/r%0d/k%0d",
                 idx, f10, inv10, round10, key10, e.flags, e.inv, e.round, e.key);
      end
      start10 = 1'b0;
      abort10 = (idx == 41);
      idx++;
    end
  endtask

  // Start held high: the second operation (decrypt of the first's output) begins
  // as soon as ready returns and must restore the original block.
  task automatic test_back_to_back();
    rec_t e;
    int idx = 0;
    @(negedge clk);
    dataIn = 128'h0123456789abcdef0123456789abcdef;
    mode10 = 1'b0; start10 = 1'b1;
    pushOp(10, 10, 1'b0);
    pushOp(10, 10, 1'b1);
    while (q10.size() > 0) begin
      @(negedge clk);
      e = q10.pop_front();
      checks++;
      if ({f10, inv10, key10} !== {e.flags, e.inv, e.key} || (e.chkRound && round10 !== e.round)) begin
        fails++;
        $display("[TB] FAIL b2b_seq idx=%0d got %b/%b/r%0d/k%0d want %b/%b/r%0d/k%0d",
                 idx, f10, inv10, round10, key10, e.flags, e.inv, e.round, e.key);
      end
      if (idx == 0)  mode10 = 1'b1;
      if (idx == 42) dataIn = blockOut();
      if (idx == 43) start10 = 1'b0;
      idx++;
    end
    mode10 = 1'b0;
    checks++;
    if (blockOut() !== 128'h0123456789abcdef0123456789abcdef) begin
      fails++; $display("[TB] FAIL b2b_roundtrip got %h want 0123456789abcdef0123456789abcdef", blockOut());
    end
  endtask

  task automatic test_reset_mid();
    rec_t e;
    int idx = 0;
    bit hit = 1'b0;
    @(negedge clk);
    mode10 = 1'b0; start10 = 1'b1;
    pushOp(10, 10, 1'b0);
    while (q10.size() > 0) begin
      @(negedge clk);
      e = q10.pop_front();
      checks++;
      if ({f10, inv10, key10} !== {e.flags, e.inv, e.key} || (e.chkRound && round10 !== e.round)) begin
        fails++;
        $display("[TB] FAIL rst_mid_seq idx=%0d got %b/%b/r%0d/k%0d want %b/%b/r%0d/k%0d",
                 idx, f10, inv10, round10, key10, e.flags, e.inv, e.round, e.key);
      end
      start10 = (idx == 5);
      if (!hit && idx == 11) begin
        rst = 1'b1;
        q10.delete();
        repeat (2) pushRec(10, {F_READY, 1'b0, 1'b1, 4'd0, 4'd0});
        pushKey10 = 4'd0;
        pushKey14 = 4'd0;
        hit = 1'b1;
      end else if (hit && idx == 13) begin
        rst = 1'b0;
        repeat (3) pushRec(10, {F_READY, 1'b0, 1'b1, 4'd0, 4'd0});
      end
      if (hit && idx == 12) begin
        checks++;
        if ({f14, inv14, round14, key14} !== {F_READY, 9'd0}) begin
          fails++; $display("[TB] FAIL rst_mid_dut14 got %b/%b/r%0d/k%0d want %b/0/r0/k0", f14, inv14, round14, key14, F_READY);
        end
      end
      idx++;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout after %0d assertions", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    buildTables();
    test_reset();
    test_encrypt();
    test_decrypt();
    test_nr14();
    test_abort();
    test_abort_idle();
    test_abort_done();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
